stall_mem_responder: RTL and testbench
======================================

Name: stall_mem_responder

Overview:
- Memory-side responder for the pipelined processor's instruction and data ports.
- Accepts one read or write request at a time and holds the initiator with Stall while the access is in flight.
- Completes with a one-cycle Done pulse after a fixed, parameterised latency.
- The fetch and memory stages each instantiate one copy. Its Stall output drives their stall inputs, and its err output is ORed into the processor err.

Parameters:
- LATENCY, 4, cycles from accept to Done. Legal range is 1..15; 0 is illegal.
- DEPTH_LOG2, 8, log2 of the number of 16-bit words in the internal array.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- Addr  input  16  byte address. Word index = Addr[DEPTH_LOG2:1].
- DataIn  input  16  write data.
- Rd  input  1  read request.
- Wr  input  1  write request.
- DataOut  output  16  read data, valid only in the Done cycle of a read.
- Done  output  1  one-cycle completion pulse.
- Stall  output  1  access in flight; the initiator must hold its request.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; latency counter = 0; latched addr, data and op cleared.
  - DataOut = 0, Done = 0, Stall = 0, err = 0.
  - Every array word is zeroed.
  - A reset asserted mid-access aborts the access. No write is committed and no Done is produced.
- States: IDLE, BUSY, RESP.
  - Done = (state == RESP).
  - Stall = (state == BUSY).
- Valid request: exactly one of Rd and Wr is high in a cycle where state is IDLE or RESP. That cycle is the accept cycle T.
- On accept at T:
  - Latch the word index, DataIn and the op.
  - If LATENCY == 1, go to RESP at T+1.
  - Otherwise go to BUSY with counter = LATENCY-2.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter is 0, go to RESP next cycle.
  - Stall is high for cycles T+1 .. T+LATENCY-1, i.e. LATENCY-1 cycles.
- RESP (cycle T+LATENCY):
  - Done = 1.
  - Read: DataOut = array[latched index].
  - Write: array[latched index] = latched data, committed at the end of this cycle. DataOut = 0 for writes.
  - A read in the very next access returns the new value.
- Back-to-back accesses:
  - A valid request seen in the RESP cycle is accepted in that same cycle, with that cycle as T.
  - If no valid request is seen, return to IDLE.
- Requests seen while BUSY are ignored; they are neither latched nor flagged. The initiator holds them, and they are accepted on the RESP cycle.
- Read-after-write in back-to-back accesses:
  - A read accepted in the RESP cycle of a write to the same index returns the newly written data.
  - Array reads happen in RESP, after the commit.
- Outside RESP, DataOut = 0.
- Error conditions set err = 1, and it holds until reset:
  - Rd and Wr both high in an accepting state. The request is dropped and the state behaves as if no request was seen.
  - Addr[0] = 1 on an accepted request. The access still proceeds using Addr[DEPTH_LOG2:1].
- Address bits above DEPTH_LOG2 are ignored, so addresses alias modulo 2^(DEPTH_LOG2+1) bytes.
- The counter is 4 bits wide.

Test Plan:
- Default params. Write Addr=0x0010, DataIn=0xBEEF, Wr=1 at T. Then a read of 0x0010 in the Done cycle.
  -> Stall=1 at T+1..T+3, Done at T+4, DataOut=0 for the write.
  -> Read Done at T+8 with DataOut=0xBEEF, Stall=1 at T+5..T+7.
- Rd held high during BUSY across three consecutive reads of 0x0000, 0x0002, 0x0004 after writing 0x1111, 0x2222, 0x3333.
  -> Exactly three Done pulses, 4 cycles apart, with DataOut 0x1111, 0x2222, 0x3333.
- Rd=1 and Wr=1 together at Addr 0x0020 while IDLE.
  -> No Stall, no Done, err=1 from the next cycle and remaining 1.
  -> A later valid read still completes normally.
- Write 0xA5A5 to Addr 0x0011 (odd).
  -> err=1, Done after 4 cycles.
  -> A read of 0x0010 returns 0xA5A5.
  -> A read of 0x0210 also returns 0xA5A5 (alias, DEPTH_LOG2=8).
- Write 0x5555 to 0x0030; drive rst=0 at T+2 (mid-BUSY) for one cycle.
  -> Stall, Done and err drop to 0 immediately.
  -> No Done pulse.
  -> A read of 0x0030 after reset returns 0x0000.
- LATENCY=1, read of 0x0000 after reset.
  -> Stall never asserts, Done at T+1 with DataOut=0x0000.
  -> Back-to-back requests give Done every cycle.

Source files
------------

// File: rtl/stall_mem_responder.sv
// stall_mem_responder: fixed-latency memory responder; clk, rst (async active-low), Addr/DataIn/Rd/Wr in, DataOut/Done/Stall/err out
module stall_mem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err
);
  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [15:0]           data_q, data_d;
  logic                  op_q, op_d;
  logic                  err_q, err_d;
  logic [15:0]           mem_q [WORDS];
  logic [15:0]           mem_d [WORDS];
  logic                  accepting, both, valid;
  logic                  addr_unused;
  assign addr_unused = ^Addr[15:DEPTH_LOG2+1];
  assign Done    = state_q == RESP;
  assign Stall   = state_q == BUSY;
  assign err     = err_q;
  assign DataOut = (state_q == RESP && !op_q) ? mem_q[idx_q] : 16'h0;
  always_comb begin
    accepting = state_q != BUSY;
    both      = accepting && Rd && Wr;
    valid     = accepting && (Rd ^ Wr);
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    op_d      = op_q;
    err_d     = err_q || both || (valid && Addr[0]);
    mem_d     = mem_q;
    if (state_q == RESP && op_q) mem_d[idx_q] = data_q;
    if (valid) begin
      state_d = (LATENCY == 1) ? RESP : BUSY;
      cnt_d   = CNT_INIT;
      idx_d   = Addr[DEPTH_LOG2:1];
      data_d  = DataIn;
      op_d    = Wr;
    end else if (state_q == BUSY) begin
      state_d = (cnt_q == 4'd0) ? RESP : BUSY;
      cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      op_q    <= op_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: tb/tb_stall_mem_responder.sv
// tb_stall_mem_responder: directed and random checks of stall_mem_responder against a transaction-level model
module tb_stall_mem_responder;
  localparam int L = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst;
  logic [15:0] addr, din, dout;
  logic        rd, wr, done, stall, err;
  logic [15:0] a1, d1, q1;
  logic        rd1, wr1, done1, stall1, err1;
  int vecs = 0;
  int miss = 0;
  logic [15:0] mm [256];
  logic [15:0] m1 [256];
  logic        err_m;
  stall_mem_responder #(.LATENCY(L), .DEPTH_LOG2(8)) u0 (
    .clk(clk), .rst(rst), .Addr(addr), .DataIn(din), .Rd(rd), .Wr(wr),
    .DataOut(dout), .Done(done), .Stall(stall), .err(err)
  );
  stall_mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) u1 (
    .clk(clk), .rst(rst), .Addr(a1), .DataIn(d1), .Rd(rd1), .Wr(wr1),
    .DataOut(q1), .Done(done1), .Stall(stall1), .err(err1)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      mm[i] = 16'h0;
      m1[i] = 16'h0;
    end
    err_m = 1'b0;
  endtask
  task automatic idle(input int n);
    rd = 1'b0;
    wr = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_done", 16'(done), 16'h0);
      chk("idle_stall", 16'(stall), 16'h0);
      chk("idle_dout", dout, 16'h0);
      chk("idle_err", 16'(err), 16'(err_m));
    end
  endtask
  task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d);
    logic [7:0] ix;
    ix   = a[8:1];
    rd   = !w;
    wr   = w;
    addr = a;
    din  = d;
    @(posedge clk);
    err_m = err_m | a[0];
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      chk("stall", 16'(stall), 16'(k < L));
      chk("done", 16'(done), 16'(k == L));
      chk("err", 16'(err), 16'(err_m));
      chk("dout", dout, (k == L && !w) ? mm[ix] : 16'h0);
    end
    if (w) mm[ix] = d;
  endtask
  initial begin
    logic        w;
    logic [15:0] a, d;
    rst = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = 16'h0; din = 16'h0;
    rd1 = 1'b0; wr1 = 1'b0; a1 = 16'h0; d1 = 16'h0;
    model_clear();
    #12;
    chk("rst_dout", dout, 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_stall", 16'(stall), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_done1", 16'(done1), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    access(1'b1, 16'h0010, 16'hBEEF);
    access(1'b0, 16'h0010, 16'h0);
    access(1'b1, 16'h0000, 16'h1111);
    access(1'b1, 16'h0002, 16'h2222);
    access(1'b1, 16'h0004, 16'h3333);
    access(1'b0, 16'h0000, 16'h0);
    access(1'b0, 16'h0002, 16'h0);
    access(1'b0, 16'h0004, 16'h0);
    idle(2);
    rd = 1'b1; wr = 1'b1; addr = 16'h0020;
    @(negedge clk);
    err_m = 1'b1;
    chk("both_stall", 16'(stall), 16'h0);
    chk("both_done", 16'(done), 16'h0);
    chk("both_err", 16'(err), 16'h1);
    idle(2);
    access(1'b0, 16'h0020, 16'h0);
    access(1'b1, 16'h0011, 16'hA5A5);
    access(1'b0, 16'h0010, 16'h0);
    access(1'b0, 16'h0210, 16'h0);
    chk("alias_model", mm[8'h08], 16'hA5A5);
    idle(1);
    wr = 1'b1; addr = 16'h0030; din = 16'h5555;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wr = 1'b0;
    #1;
    model_clear();
    chk("arst_stall", 16'(stall), 16'h0);
    chk("arst_done", 16'(done), 16'h0);
    chk("arst_err", 16'(err), 16'h0);
    chk("arst_dout", dout, 16'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(5);
    access(1'b0, 16'h0030, 16'h0);
    access(1'b0, 16'h0010, 16'h0);
    repeat (40) begin
      w = 1'($urandom_range(0, 1));
      a = 16'($urandom) & 16'hFE1E;
      if ($urandom_range(0, 15) == 0) a[0] = 1'b1;
      d = 16'($urandom);
      access(w, a, d);
      idle($urandom_range(0, 2));
    end
    idle(1);
    for (int i = 0; i < 9; i++) begin
      wr1 = (i >= 1 && i <= 4);
      rd1 = !wr1;
      a1  = (i == 0) ? 16'h0 : 16'(((i - 1) % 4) * 2);
      d1  = 16'h1000 + 16'(i * 16'h0111);
      @(negedge clk);
      chk("l1_done", 16'(done1), 16'h1);
      chk("l1_stall", 16'(stall1), 16'h0);
      chk("l1_dout", q1, wr1 ? 16'h0 : m1[a1[8:1]]);
      chk("l1_err", 16'(err1), 16'h0);
      if (wr1) m1[a1[8:1]] = d1;
    end
    chk("l1_model", m1[8'h01], 16'h1222);
    rd1 = 1'b0; wr1 = 1'b0;
    @(negedge clk);
    chk("l1_idle_done", 16'(done1), 16'h0);
    chk("l1_idle_dout", q1, 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
